inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
Parametrised instruction-fetch front end for the RV32 core; replaces the single-register fetch stage.
- Issues in-order fetch requests over a valid/ready bus and buffers up to DEPTH returned words.
- Presents one instruction per cycle to decode, with hold, bubble-insert and jump-flush control from the control unit.
- Adds what the single-register fetch stage lacks: multiple outstanding fetches, a request/response handshake, and discard of in-flight words after a jump.

Parameters:
- DEPTH, 4, queue entries; also the maximum number of outstanding requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, word presented on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- hold  in  1  freeze decode-facing outputs; no pop.
- nop  in  1  present a bubble this cycle; no pop.
- jmp_vld  in  1  redirect fetch; flush the queue.
- jmp_addr  in  32  redirect target; word-aligned.
- mem_req_vld  out  1  fetch request valid.
- mem_req_rdy  in  1  memory accepts the request.
- mem_req_addr  out  32  fetch address.
- mem_rsp_vld  in  1  response word valid; in order; always accepted.
- mem_rsp_data  in  32  response instruction.
- IF_vld  out  1  IF_inst is a real instruction.
- IF_pc  out  32  pc of IF_inst.
- IF_inst  out  32  instruction to decode.

Behaviour:
- Reset (rst=0 at a clock edge):
  - fetch_pc <= RESET_PC; queue empty; outstanding count = 0; discard count = 0.
  - Outputs: IF_vld=0, IF_pc=0, IF_inst=NOP_INST, mem_req_vld=0, mem_req_addr=RESET_PC.
  - Reset applied mid-operation abandons in-flight requests. The memory side is reset in the same domain, so no discard is needed.
- Request side:
  - mem_req_vld=1 when occupancy + outstanding < DEPTH and jmp_vld=0.
  - mem_req_addr = fetch_pc.
  - On a handshake: fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
- Response side:
  - A response decrements outstanding.
  - If discard count > 0, the word is dropped and discard count decrements.
  - Otherwise the word is pushed with its pc. The pc comes from rsp_pc, a register advanced by 4 per kept response and loaded with jmp_addr on a flush.
  - The credit rule guarantees a push never hits a full queue.
- Output register (updated every edge). Priority: rst > jmp_vld > hold > nop > pop.
  - jmp_vld: IF_vld=0, IF_inst=NOP_INST. Queue cleared. fetch_pc <= jmp_addr. discard count <= outstanding after this cycle's request/response updates. Any request handshake in the same cycle is counted as outstanding and will be discarded. The first request to jmp_addr issues the next cycle.
  - hold: all IF_* outputs hold their values; queue not popped; pushes still occur.
  - nop: IF_vld=0, IF_inst=NOP_INST, IF_pc unchanged; no pop.
  - Otherwise, if the queue is non-empty, pop the head to IF_pc/IF_inst and set IF_vld=1.
  - Otherwise (empty), bubble as for nop.
- Latency:
  - A response arriving at edge N is pushed at N. It can appear on IF_inst at edge N+1 if the queue was empty. There is no bypass.
- Simultaneous events:
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
  - A response in the same cycle as jmp_vld is dropped. It does not count toward the new discard total, because outstanding is decremented first.
- Counters:
  - outstanding and discard are $clog2(DEPTH+1) bits wide and saturate neither way.
  - Verification asserts no under/overflow and discard <= outstanding.

Decomposition:
- Shared package/defines:
  - NOP encoding 32'h0000_0013.
  - The fetch bus field widths.
- One sub-module: sync_fifo.
  - Parameters: WIDTH=64 ({pc, inst}), DEPTH.
  - Ports: push, pop, clear, full, empty, count.
  - Wrap-around read/write pointers with one extra bit for full/empty detection.
  - clear has priority over push/pop.
- The top level holds the request counters, the pc registers and the output-priority logic.

Test Plan:
- Reset then free-running memory (mem_req_rdy=1, 1-cycle response latency): IF_pc = 0,4,8,… with IF_vld=1 every cycle once primed; first valid at edge 3 after reset release.
- mem_req_rdy=1 with decode held for 10 cycles (DEPTH=4): mem_req_vld drops after exactly 4 requests beyond the presented word; release hold: words emerge 4,8,12,16 in order with no loss.
- 3-cycle response latency, 3 outstanding, jmp_vld with jmp_addr=32'h100: the next 3 responses are dropped; first IF_vld=1 shows IF_pc=32'h100; no stale word ever appears.
- jmp_vld asserted together with hold and nop: jump wins; IF_vld=0 and IF_inst=32'h13 on the next edge; queue count = 0.
- nop pulse while the queue holds 2 entries: one bubble (IF_vld=0, IF_inst=32'h13, IF_pc unchanged); the next cycle pops the expected word; count unchanged across the bubble.
- fetch_pc=32'hFFFF_FFFC: the next request is at 32'h0000_0000; assert rst=0 while 2 requests are outstanding: all outputs return to reset values and the first request after release is to RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and encodings for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

  localparam int unsigned XLEN       = 32;
  localparam logic [XLEN-1:0] NOP_ENC    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    OUT_FLUSH,
    OUT_HOLD,
    OUT_BUBBLE,
    OUT_POP
  } out_sel_e;

endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers; clear overrides push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_diff;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_diff    = r_wptr - r_rptr;
  assign o_count   = CW'(w_diff);
  assign o_full    = (w_diff == (AW+1)'(DEPTH));
  assign o_empty   = (r_wptr == r_rptr);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front end: credit-limited request issue, response queue,
// jump flush with in-flight discard, and a registered decode-facing output.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        nop,
  input  logic        jmp_vld,
  input  logic [31:0] jmp_addr,
  output logic        mem_req_vld,
  input  logic        mem_req_rdy,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_vld,
  input  logic [31:0] mem_rsp_data,
  output logic        IF_vld,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic         r_if_vld;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_inst;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_keep;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_discard_next;
  out_sel_e      w_sel;

  // Queued words plus words still in flight may never exceed the queue size.
  assign w_credit     = ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
  assign mem_req_vld  = rst & ~jmp_vld & w_credit;
  assign mem_req_addr = r_fetch_pc;
  assign w_req_fire   = mem_req_vld & mem_req_rdy;
  assign w_out_next   = r_outstanding + CW'(w_req_fire) - CW'(mem_rsp_vld);
  assign w_keep       = mem_rsp_vld & (r_discard == '0) & ~jmp_vld;
  assign w_push_entry = '{pc: r_rsp_pc, inst: mem_rsp_data};
  assign w_pop        = (w_sel == OUT_POP);

  always_comb begin
    w_sel = OUT_POP;
    if (jmp_vld)      w_sel = OUT_FLUSH;
    else if (hold)    w_sel = OUT_HOLD;
    else if (nop)     w_sel = OUT_BUBBLE;
    else if (w_empty) w_sel = OUT_BUBBLE;
  end

  // A flush discards everything still in flight after this cycle's updates.
  always_comb begin
    w_discard_next = r_discard;
    if (jmp_vld)
      w_discard_next = w_out_next;
    else if (mem_rsp_vld && (r_discard != '0))
      w_discard_next = r_discard - 1'b1;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_clear (jmp_vld),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      if (jmp_vld)         r_fetch_pc <= jmp_addr;
      else if (w_req_fire) r_fetch_pc <= r_fetch_pc + INST_BYTES;
      if (jmp_vld)         r_rsp_pc   <= jmp_addr;
      else if (w_keep)     r_rsp_pc   <= r_rsp_pc + INST_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_vld  <= 1'b0;
      r_if_pc   <= '0;
      r_if_inst <= NOP_INST;
    end else begin
      case (w_sel)
        OUT_FLUSH, OUT_BUBBLE: begin
          r_if_vld  <= 1'b0;
          r_if_inst <= NOP_INST;
        end
        OUT_POP: begin
          r_if_vld  <= 1'b1;
          r_if_pc   <= w_head.pc;
          r_if_inst <= w_head.inst;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_keep && w_full));
      assert (r_discard <= r_outstanding);
      assert (!(mem_rsp_vld && (r_outstanding == '0)));
      assert (!(w_req_fire && (r_outstanding == CW'(DEPTH))));
    end
  end

  assign IF_vld  = r_if_vld;
  assign IF_pc   = r_if_pc;
  assign IF_inst = r_if_inst;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with an in-order latency memory model.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst, hold, nop, jmp_vld;
  logic [31:0] jmp_addr;
  logic        mem_req_vld, mem_req_rdy, mem_rsp_vld;
  logic [31:0] mem_req_addr, mem_rsp_data;
  logic        IF_vld;
  logic [31:0] IF_pc, IF_inst;

  int unsigned npass = 0;
  int unsigned nchk  = 0;
  int unsigned nfail = 0;
  int          lat   = 1;
  int          e     = 0;
  int          nreq  = 0;
  int          n;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  inst_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .nop          (nop),
    .jmp_vld      (jmp_vld),
    .jmp_addr     (jmp_addr),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_vld  (mem_rsp_vld),
    .mem_rsp_data (mem_rsp_data),
    .IF_vld       (IF_vld),
    .IF_pc        (IF_pc),
    .IF_inst      (IF_inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the bus before the edge, then update the memory model.
  task automatic cyc();
    logic        fire, rsp, in_rst;
    logic [31:0] a;
    @(negedge clk);
    fire   = mem_req_vld & mem_req_rdy;
    a      = mem_req_addr;
    rsp    = mem_rsp_vld;
    in_rst = ~rst;
    @(posedge clk);
    #1;
    e++;
    if (in_rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (rsp) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (fire) begin
        pend_addr.push_back(a);
        pend_due.push_back(e + lat);
        nreq++;
      end
    end
    if (pend_due.size() > 0 && pend_due[0] == e + 1) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_data = mem_word(pend_addr[0]);
    end else begin
      mem_rsp_vld  = 1'b0;
      mem_rsp_data = '0;
    end
  endtask

  task automatic wait_vld(input string tag, input int bound, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (IF_vld !== 1'b1 && cycles < bound);
    chk(tag, 32'(IF_vld), 32'd1);
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; nop = 1'b0; jmp_vld = 1'b0; jmp_addr = '0;
    mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0; mem_rsp_data = '0;

    // Reset state
    repeat (2) cyc();
    chk("rst_if_vld",   32'(IF_vld), 32'd0);
    chk("rst_if_pc",    IF_pc, 32'h0);
    chk("rst_if_inst",  IF_inst, 32'h13);
    chk("rst_req_vld",  32'(mem_req_vld), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);

    // Free-running memory, 1-cycle latency
    rst = 1'b1;
    cyc(); chk("e1_vld", 32'(IF_vld), 32'd0);
    cyc(); chk("e2_vld", 32'(IF_vld), 32'd0);
    cyc(); chk("e3_vld", 32'(IF_vld), 32'd1);
    chk("e3_pc", IF_pc, 32'h0);
    chk("e3_inst", IF_inst, mem_word(32'h0));
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("stream_vld", 32'(IF_vld), 32'd1);
      chk("stream_pc", IF_pc, 32'(4 * i));
      chk("stream_inst", IF_inst, mem_word(32'(4 * i)));
    end

    // Hold for 10 cycles with the queue filling up
    rst = 1'b0; cyc(); rst = 1'b1; nreq = 0;
    repeat (3) cyc();
    chk("h_pc0", IF_pc, 32'h0);
    hold = 1'b1;
    repeat (10) cyc();
    chk("hold_vld", 32'(IF_vld), 32'd1);
    chk("hold_pc", IF_pc, 32'h0);
    chk("hold_req_vld", 32'(mem_req_vld), 32'd0);
    chk("hold_nreq", 32'(nreq), 32'd5);
    chk("hold_req_addr", mem_req_addr, 32'h14);
    hold = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("unhold_vld", 32'(IF_vld), 32'd1);
      chk("unhold_pc", IF_pc, 32'(4 * i));
      chk("unhold_inst", IF_inst, mem_word(32'(4 * i)));
    end

    // Jump with three requests in flight (4-edge latency, none coincident)
    rst = 1'b0; cyc(); rst = 1'b1; lat = 4; nreq = 0;
    repeat (3) cyc();
    chk("j_nreq", 32'(nreq), 32'd3);
    jmp_vld = 1'b1; jmp_addr = 32'h100;
    #1;
    chk("j_req_blocked", 32'(mem_req_vld), 32'd0);
    cyc();
    jmp_vld = 1'b0;
    chk("j_if_vld", 32'(IF_vld), 32'd0);
    chk("j_if_inst", IF_inst, 32'h13);
    chk("j_req_addr", mem_req_addr, 32'h100);
    wait_vld("j_first_to", 20, n);
    chk("j_first_pc", IF_pc, 32'h100);
    chk("j_first_inst", IF_inst, mem_word(32'h100));
    chk("j_latency", 32'(n), 32'd6);
    wait_vld("j_second_to", 10, n);
    chk("j_second_pc", IF_pc, 32'h104);
    wait_vld("j_third_to", 10, n);
    chk("j_third_pc", IF_pc, 32'h108);

    // Jump together with hold and nop
    rst = 1'b0; cyc(); rst = 1'b1; lat = 1;
    repeat (5) cyc();
    chk("jhn_pre_pc", IF_pc, 32'h8);
    jmp_vld = 1'b1; hold = 1'b1; nop = 1'b1; jmp_addr = 32'h200;
    cyc();
    jmp_vld = 1'b0; hold = 1'b0; nop = 1'b0;
    chk("jhn_vld", 32'(IF_vld), 32'd0);
    chk("jhn_inst", IF_inst, 32'h13);
    chk("jhn_count", 32'(dut.w_count), 32'd0);
    wait_vld("jhn_first_to", 10, n);
    chk("jhn_first_pc", IF_pc, 32'h200);
    chk("jhn_latency", 32'(n), 32'd3);

    // Bubble with two queued entries
    mem_req_rdy = 1'b0; hold = 1'b1;
    cyc();
    hold = 1'b0;
    chk("nop_pre_count", 32'(dut.w_count), 32'd2);
    nop = 1'b1;
    cyc();
    nop = 1'b0;
    chk("nop_vld", 32'(IF_vld), 32'd0);
    chk("nop_inst", IF_inst, 32'h13);
    chk("nop_pc", IF_pc, 32'h200);
    chk("nop_count", 32'(dut.w_count), 32'd2);
    cyc();
    chk("nop_next_vld", 32'(IF_vld), 32'd1);
    chk("nop_next_pc", IF_pc, 32'h204);
    chk("nop_next_inst", IF_inst, mem_word(32'h204));
    cyc();
    chk("nop_next2_pc", IF_pc, 32'h208);
    cyc();
    chk("empty_vld", 32'(IF_vld), 32'd0);
    chk("empty_pc", IF_pc, 32'h208);

    // Address wrap at the top of memory
    mem_req_rdy = 1'b1; jmp_vld = 1'b1; jmp_addr = 32'hFFFF_FFF8;
    cyc();
    jmp_vld = 1'b0;
    chk("wrap_addr0", mem_req_addr, 32'hFFFF_FFF8);
    cyc(); chk("wrap_addr1", mem_req_addr, 32'hFFFF_FFFC);
    cyc(); chk("wrap_addr2", mem_req_addr, 32'h0000_0000);
    cyc(); chk("wrap_if0", IF_pc, 32'hFFFF_FFF8);
    chk("wrap_if0_vld", 32'(IF_vld), 32'd1);
    cyc(); chk("wrap_if1", IF_pc, 32'hFFFF_FFFC);
    cyc(); chk("wrap_if2", IF_pc, 32'h0000_0000);
    chk("wrap_if2_inst", IF_inst, mem_word(32'h0));
    cyc(); chk("wrap_if3", IF_pc, 32'h0000_0004);

    // Reset with two requests outstanding
    lat = 2;
    repeat (4) cyc();
    chk("pre_rst_outstanding", 32'(dut.r_outstanding), 32'd2);
    rst = 1'b0;
    cyc();
    chk("mrst_if_vld",   32'(IF_vld), 32'd0);
    chk("mrst_if_pc",    IF_pc, 32'h0);
    chk("mrst_if_inst",  IF_inst, 32'h13);
    chk("mrst_req_vld",  32'(mem_req_vld), 32'd0);
    chk("mrst_req_addr", mem_req_addr, 32'h0);
    rst = 1'b1; lat = 1;
    #1;
    chk("mrst_first_vld",  32'(mem_req_vld), 32'd1);
    chk("mrst_first_addr", mem_req_addr, 32'h0);
    wait_vld("mrst_if_to", 10, n);
    chk("mrst_if_first_pc", IF_pc, 32'h0);
    chk("mrst_if_latency", 32'(n), 32'd3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
